decode_window_ctrl: RTL and testbench

DECODE_WINDOW_CTRL -- requirements
Module: decode_window_ctrl

---
 rtl/decode_window_ctrl_pkg.sv | 31 +++
 rtl/decode_window_ctrl_shifter.sv | 26 ++
 rtl/decode_window_ctrl.sv | 117 +++++++++++
 tb/tb_decode_window_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_window_ctrl_pkg.sv
// rtl/decode_window_ctrl_pkg.sv - byte-window constants and controller state encoding
package decode_window_ctrl_pkg;

  localparam int WIN   = 11;
  localparam int BUF   = 16;
  localparam int WIN_W = WIN * 8;
  localparam int BUF_W = BUF * 8;

  localparam logic [4:0] WIN_BYTES  = 5'd11;
  localparam logic [4:0] PUSH_LIMIT = 5'd12;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_FILL  = 3'd1,
    ST_READY = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Steady-state classification of a live (non-draining) buffer by its byte count.
  function automatic state_t fill_state(input logic [4:0] c);
    if (c == 5'd0) begin
      return ST_EMPTY;
    end else if (c < WIN_BYTES) begin
      return ST_FILL;
    end else begin
      return ST_READY;
    end
  endfunction

endpackage

// File: rtl/decode_window_ctrl_shifter.sv
// rtl/decode_window_ctrl_shifter.sv - combined consume-shift and fetch-append byte datapath
module decode_byte_shifter
  import decode_window_ctrl_pkg::*;
(
  input  logic [BUF_W-1:0] buf_i,
  input  logic [4:0]       cnt_i,
  input  logic [3:0]       shift_len_i,
  input  logic             push_i,
  input  logic [31:0]      push_data_i,
  output logic [BUF_W-1:0] buf_o,
  output logic [4:0]       cnt_o
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] inserted;
  logic [4:0]       base;

  // Zeros shift in from the top, so bytes above the count stay 0 and the append can OR in.
  assign shifted  = buf_i >> {shift_len_i, 3'b000};
  assign base     = cnt_i - {1'b0, shift_len_i};
  assign inserted = {{(BUF_W-32){1'b0}}, push_data_i} << {base, 3'b000};

  assign buf_o = push_i ? (shifted | inserted) : shifted;
  assign cnt_o = push_i ? (base + 5'd4) : base;

endmodule

// File: rtl/decode_window_ctrl.sv
// rtl/decode_window_ctrl.sv - fetch-word to decode-window byte buffer controller
module decode_window_ctrl
  import decode_window_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        flush,
  output logic        win_valid,
  output logic [87:0] win_bytes,
  input  logic        win_ready,
  input  logic [3:0]  win_len,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_count
);

  logic [BUF_W-1:0] buf_q, buf_d, shift_buf;
  logic [4:0]       cnt_q, cnt_d, shift_cnt;
  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [15:0]      instr_q, instr_d;

  logic push, consume, len_ok, consume_ok, len_err;
  logic [3:0] shift_len;

  assign in_ready = ((state_q == ST_EMPTY) || (state_q == ST_FILL) || (state_q == ST_READY))
                    && (cnt_q <= PUSH_LIMIT);
  assign win_valid = (state_q != ST_ERROR)
                     && ((cnt_q >= WIN_BYTES) || ((state_q == ST_DRAIN) && (cnt_q != 5'd0)));

  assign push       = in_valid && in_ready;
  assign consume    = win_valid && win_ready;
  assign len_ok     = (win_len != 4'd0) && ({1'b0, win_len} <= WIN_BYTES)
                      && ({1'b0, win_len} <= cnt_q);
  assign consume_ok = consume && len_ok;
  assign len_err    = consume && !len_ok;
  assign shift_len  = consume_ok ? win_len : 4'd0;

  decode_byte_shifter u_shifter (
    .buf_i       (buf_q),
    .cnt_i       (cnt_q),
    .shift_len_i (shift_len),
    .push_i      (push),
    .push_data_i (in_data),
    .buf_o       (shift_buf),
    .cnt_o       (shift_cnt)
  );

  always_comb begin
    buf_d   = shift_buf;
    cnt_d   = shift_cnt;
    state_d = state_q;
    err_d   = err_q;
    done_d  = 1'b0;
    instr_d = consume_ok ? (instr_q + 16'd1) : instr_q;

    if (flush) begin
      buf_d   = '0;
      cnt_d   = 5'd0;
      state_d = ST_EMPTY;
      err_d   = 1'b0;
      instr_d = 16'd0;
    end else if (len_err) begin
      buf_d   = '0;
      cnt_d   = 5'd0;
      state_d = ST_ERROR;
      err_d   = 1'b1;
      instr_d = instr_q;
    end else begin
      case (state_q)
        ST_ERROR: state_d = ST_ERROR;
        ST_DRAIN: begin
          if (shift_cnt == 5'd0) begin
            state_d = ST_EMPTY;
            done_d  = 1'b1;
          end
        end
        default: begin
          if (push && in_last) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = fill_state(shift_cnt);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= 5'd0;
      state_q <= ST_EMPTY;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      instr_q <= 16'd0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
      instr_q <= instr_d;
    end
  end

  assign win_bytes   = buf_q[WIN_W-1:0];
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_decode_window_ctrl.sv
// tb/tb_decode_window_ctrl.sv - scoreboard bench for decode_window_ctrl
module tb_decode_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        flush;
  logic        win_valid;
  logic [87:0] win_bytes;
  logic        win_ready;
  logic [3:0]  win_len;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  logic [87:0] exp_q[$];
  logic [87:0] sb_exp;

  decode_window_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .flush       (flush),
    .win_valid   (win_valid),
    .win_bytes   (win_bytes),
    .win_ready   (win_ready),
    .win_len     (win_len),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_win(input logic [87:0] w);
    exp_q.push_back(w);
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic il,
                      input logic wr, input logic [3:0] wl, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_last   = il;
    win_ready = wr;
    win_len   = wl;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    win_ready = 1'b0;
    win_len   = 4'd0;
    flush     = 1'b0;
  endtask

  function automatic logic [31:0] ramp_word(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  function automatic logic [87:0] ramp_win(input int start);
    logic [87:0] r;
    for (int j = 0; j < 11; j++) r[j*8 +: 8] = 8'(start + j);
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_bytes"}, win_bytes, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_instr_count"}, instr_count, 0);
  endtask

  // Scoreboard monitor: every accepted window is compared against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done === 1'b1) done_pulses++;
        if (win_valid === 1'b1 && win_ready === 1'b1 && flush === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=handshake expected=none");
          end else begin
            sb_exp = exp_q.pop_front();
            check("sb_win_bytes", win_bytes, sb_exp);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    flush = 1'b0; win_ready = 1'b0; win_len = 4'd0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    step(1, 32'h03020100, 0, 0, 0, 0);
    check("fill1_win_valid", win_valid, 0);
    step(1, 32'h07060504, 0, 0, 0, 0);
    step(1, 32'h0B0A0908, 0, 0, 0, 0);
    check("fill3_win_valid", win_valid, 1);
    check("fill3_win_bytes", win_bytes, 88'h0A09080706050403020100);
    check("fill3_in_ready", in_ready, 1);

    expect_win(88'h0A09080706050403020100);
    step(1, 32'h0F0E0D0C, 0, 1, 3, 0);
    check("pc_win_bytes", win_bytes, 88'h0D0C0B0A090807060504_03);
    check("pc_byte0", win_bytes[7:0], 8'h03);
    check("pc_instr_count", instr_count, 1);
    check("pc_in_ready_cnt13", in_ready, 0);

    step(1, 32'h11111111, 0, 1, 2, 1);
    check("flush_win_bytes", win_bytes, 0);
    check("flush_win_valid", win_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_instr_count", instr_count, 0);
    step(1, 32'h44332211, 0, 0, 0, 0);
    check("post_flush_push", win_bytes, 88'h44332211);
    step(1, 32'h55555555, 0, 0, 0, 1);
    check("flush_push_win_bytes", win_bytes, 0);
    step(1, 32'h99887766, 0, 0, 0, 0);
    check("no_retained_bytes", win_bytes, 88'h99887766);

    step(0, 32'd0, 0, 1, 4, 0);
    check("ignore_rdy_win_bytes", win_bytes, 88'h99887766);
    check("ignore_rdy_instr_count", instr_count, 0);
    check("ignore_rdy_err", err, 0);
    step(0, 32'd0, 0, 0, 0, 1);

    step(1, 32'hDDCCBBAA, 1, 0, 0, 0);
    check("drain_win_valid", win_valid, 1);
    check("drain_in_ready", in_ready, 0);
    check("drain_win_bytes", win_bytes, 88'hDDCCBBAA);
    expect_win(88'hDDCCBBAA);
    step(0, 32'd0, 0, 1, 2, 0);
    check("drain2_win_bytes", win_bytes, 88'hDDCC);
    check("drain2_done", done, 0);
    check("drain2_win_valid", win_valid, 1);
    expect_win(88'hDDCC);
    step(0, 32'd0, 0, 1, 2, 0);
    check("drained_done", done, 1);
    check("drained_win_valid", win_valid, 0);
    check("drained_in_ready", in_ready, 1);
    check("drained_instr_count", instr_count, 2);
    step(0, 32'd0, 0, 0, 0, 0);
    check("done_cleared", done, 0);
    check("done_once", done_pulses, 1);

    step(1, 32'h04030201, 0, 0, 0, 0);
    step(1, 32'h08070605, 0, 0, 0, 0);
    step(1, 32'h0C0B0A09, 0, 0, 0, 0);
    check("err_fill_win_bytes", win_bytes, 88'h0B0A090807060504030201);
    expect_win(88'h0B0A090807060504030201);
    step(0, 32'd0, 0, 1, 12, 0);
    check("len12_err", err, 1);
    check("len12_win_valid", win_valid, 0);
    check("len12_in_ready", in_ready, 0);
    check("len12_instr_count", instr_count, 2);
    check("len12_win_bytes", win_bytes, 0);
    step(1, 32'hAAAAAAAA, 0, 1, 3, 0);
    check("err_hold_err", err, 1);
    check("err_hold_in_ready", in_ready, 0);
    check("err_hold_win_valid", win_valid, 0);
    step(0, 32'd0, 0, 0, 0, 1);
    check("err_flush_err", err, 0);
    check("err_flush_win_valid", win_valid, 0);
    check("err_flush_in_ready", in_ready, 1);
    check("err_flush_instr_count", instr_count, 0);
    check("err_flush_win_bytes", win_bytes, 0);

    step(1, 32'h04030201, 0, 0, 0, 0);
    step(1, 32'h08070605, 0, 0, 0, 0);
    step(1, 32'h0C0B0A09, 0, 0, 0, 0);
    expect_win(88'h0B0A090807060504030201);
    step(0, 32'd0, 0, 1, 0, 0);
    check("len0_err", err, 1);
    check("len0_instr_count", instr_count, 0);
    step(0, 32'd0, 0, 0, 0, 1);

    for (int k = 0; k < 3; k++) step(1, ramp_word(k), 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) check("wrap_pre_count", instr_count, 16'hFFFF);
      expect_win(ramp_win(4*i));
      step(1, ramp_word(i+3), 0, 1, 4, 0);
    end
    check("wrap_instr_count", instr_count, 0);
    check("wrap_win_bytes", win_bytes, ramp_win(4*65536));
    check("wrap_in_ready", in_ready, 1);

    step(1, ramp_word(65539), 1, 0, 0, 0);
    check("pre_rst_win_valid", win_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 32'h12345678, 0, 0, 0, 0);
    check("post_rst_no_drain", win_valid, 0);
    check("post_rst_win_bytes", win_bytes, 88'h12345678);

    check("sb_drained", exp_q.size(), 0);
    check("done_total", done_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
